// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between the CPU controller and a DMA port
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);
  state_t state, state_nxt;
  logic [3:0] starve_cnt;
  logic [2:0] wait_cnt;
  logic hold_we;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;
  logic grant, dma_win, last_wait;
  always_comb begin
    grant = state == IDLE && (cpu_req || dma_req);
    dma_win = dma_req && (!cpu_req || starve_cnt == LIMIT);
    last_wait = state == WAIT && wait_cnt == '0;
    state_nxt = state == IDLE  ? (grant ? ISSUE : IDLE) :
                state == ISSUE ? (hold_we ? DONE : WAIT) :
                state == WAIT  ? (last_wait ? DONE : WAIT) : IDLE;
    mem_en = state == ISSUE;
    mem_we = mem_en && hold_we;
    mem_addr = mem_en ? hold_addr : '0;
    mem_wdata = mem_en ? hold_wdata : '0;
    busy = state != IDLE;
    cpu_ack = state == DONE && !owner;
    dma_ack = state == DONE && owner;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      owner <= 1'b0;
      starve_cnt <= '0;
      wait_cnt <= '0;
      hold_we <= 1'b0;
      hold_addr <= '0;
      hold_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (grant) begin
        owner <= dma_win;
        hold_we <= dma_win ? dma_we : cpu_we;
        hold_addr <= dma_win ? dma_addr : cpu_addr;
        hold_wdata <= dma_win ? dma_wdata : cpu_wdata;
        starve_cnt <= dma_win ? '0 : (dma_req && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
      end
      wait_cnt <= state == ISSUE ? WAIT_INIT : state == WAIT ? wait_cnt - 3'd1 : wait_cnt;
      if (last_wait && owner) dma_rdata <= mem_rdata;
      if (last_wait && !owner) cpu_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized req/ack traffic against a timestamped transaction model
module tb_mem_port_arbiter;
  localparam int RL = 3;
  localparam int SL = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] cpu_addr = '0, dma_addr = '0;
  logic [15:0] cpu_wdata = '0, dma_wdata = '0;
  logic cpu_ack, dma_ack, mem_en, mem_we, busy, owner;
  logic [7:0] mem_addr;
  logic [15:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [15:0] tb_ram [256];
  bit tb_wr [256];
  logic [15:0] pipe [RL];
  logic [15:0] ref_ram [256];
  int n_tests = 0, n_fail = 0, k = 0;
  int idle_from = 0, t_issue = -1, t_ack = -1, m_starve = 0;
  bit t_who = 0, t_we = 0, m_owner = 0;
  logic [7:0] t_addr = '0;
  logic [15:0] t_wdata = '0, m_cpu_rd = '0, m_dma_rd = '0;
  int cpu_rate, dma_rate, renew;
  bit dma_rd_only = 0, did_rst = 0, rst_now = 0, cpu_ack_d = 0, dma_ack_d = 0;

  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return {a ^ 8'hA5, ~a};
  endfunction

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      tb_ram[mem_addr] <= mem_wdata;
      tb_wr[mem_addr] <= 1'b1;
    end
    pipe[0] <= mem_en ? (tb_wr[mem_addr] ? tb_ram[mem_addr] : init_val(mem_addr)) : 16'($urandom);
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[RL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit en_x;
    en_x = k == t_issue;
    if (k == t_ack && !t_we) begin
      if (t_who) m_dma_rd = ref_ram[t_addr];
      else m_cpu_rd = ref_ram[t_addr];
    end
    check("mem_en", mem_en, en_x);
    check("mem_we", mem_we, en_x && t_we);
    check("mem_addr", mem_addr, en_x ? t_addr : 8'h0);
    check("mem_wdata", mem_wdata, en_x ? t_wdata : 16'h0);
    check("cpu_ack", cpu_ack, k == t_ack && !t_who);
    check("dma_ack", dma_ack, k == t_ack && t_who);
    check("one_ack", cpu_ack && dma_ack, 1'b0);
    check("busy", busy, k < idle_from);
    check("owner", owner, m_owner);
    check("cpu_rdata", cpu_rdata, m_cpu_rd);
    check("dma_rdata", dma_rdata, m_dma_rd);
  endtask

  task automatic cpu_new();
    cpu_req = 1'b1;
    cpu_we = 1'($urandom_range(0, 1));
    cpu_addr = 8'($urandom_range(0, 15));
    cpu_wdata = 16'($urandom);
  endtask

  task automatic dma_new();
    dma_req = 1'b1;
    dma_we = dma_rd_only ? 1'b0 : 1'($urandom_range(0, 1));
    dma_addr = 8'($urandom_range(0, 15));
    dma_wdata = 16'($urandom);
  endtask

  task automatic drive_agents();
    if (cpu_ack_d) begin
      if ($urandom_range(0, 99) < renew) cpu_new();
      else cpu_req = 1'b0;
    end else if (!cpu_req && $urandom_range(0, 99) < cpu_rate) cpu_new();
    if (dma_ack_d) begin
      if ($urandom_range(0, 99) < renew) dma_new();
      else dma_req = 1'b0;
    end else if (!dma_req && $urandom_range(0, 99) < dma_rate) dma_new();
    cpu_ack_d = cpu_ack;
    dma_ack_d = dma_ack;
  endtask

  task automatic model_step();
    bit dwin;
    if (rst_now) begin
      idle_from = k + 1;
      t_issue = -1;
      t_ack = -1;
      t_we = 0;
      m_starve = 0;
      m_owner = 0;
      m_cpu_rd = '0;
      m_dma_rd = '0;
      return;
    end
    if (k < idle_from || !(cpu_req || dma_req)) return;
    dwin = dma_req && (!cpu_req || m_starve == SL);
    m_starve = dwin ? 0 : (dma_req && m_starve < SL) ? m_starve + 1 : m_starve;
    m_owner = dwin;
    t_who = dwin;
    t_we = dwin ? dma_we : cpu_we;
    t_addr = dwin ? dma_addr : cpu_addr;
    t_wdata = dwin ? dma_wdata : cpu_wdata;
    t_issue = k + 1;
    t_ack = k + 2 + (t_we ? 0 : RL);
    idle_from = t_ack + 1;
    if (t_we) ref_ram[t_addr] = t_wdata;
  endtask

  task automatic set_phase();
    dma_rd_only = 0;
    if (k < 400) begin cpu_rate = 40; dma_rate = 30; renew = 25; end
    else if (k < 600) begin cpu_rate = 100; dma_rate = 100; renew = 100; end
    else if (k < 800) begin cpu_rate = 100; dma_rate = 0; renew = 0; end
    else if (k < 900) begin cpu_rate = 0; dma_rate = 100; renew = 0; end
    else if (k < 1000) begin cpu_rate = 0; dma_rate = 100; renew = 50; dma_rd_only = 1; end
    else begin cpu_rate = 50; dma_rate = 50; renew = 30; end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_ram[i] = init_val(8'(i));
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (k = 0; k < 1400; k++) begin
      check_cycle();
      set_phase();
      rst_now = !did_rst && k >= 900 && t_who && !t_we && k > t_issue && k < t_ack;
      if (rst_now) begin
        did_rst = 1;
        reset = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        cpu_ack_d = 0;
        dma_ack_d = 0;
      end else begin
        reset = 1'b0;
        drive_agents();
      end
      model_step();
      @(negedge clock);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
